time_set_controller: RTL and testbench
======================================

Name: time_set_controller

Overview:
- Front-panel time-setting initiator: turns raw mode/up/down/cancel buttons into an edit session over hour, minute and second fields.
- Ends the session with a single-cycle set_time pulse plus input_hour/min/sec values, wired directly to the clock keeper's set interface.
- Exposes the edit values and the active field so the display path can show the time while it is being edited.

Parameters:
- TIMEOUT, 1000, idle cycles in any edit state before the session aborts without commit (1..65535).
- REPEAT_DELAY, 8, cycles after a press before auto-repeat starts (>=2).
- REPEAT_RATE, 4, cycles between auto-repeat steps (>=1).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- btn_mode  input  1  level, already debounced; advances field / enters edit
- btn_up  input  1  level, debounced; increments active field
- btn_down  input  1  level, debounced; decrements active field
- btn_cancel  input  1  level, debounced; aborts session
- current_24_hour  input  8  live hour, 0..23
- current_24_min  input  8  live minute, 0..59
- current_24_sec  input  8  live second, 0..59
- set_time  output  1  one-cycle commit strobe
- input_hour  output  8  hour to load, valid while set_time=1
- input_min  output  8  minute to load
- input_sec  output  8  second to load
- editing  output  1  high in any EDIT state
- edit_field  output  2  0=none, 1=hour, 2=min, 3=sec
- edit_hour, edit_min, edit_sec  output  8 each  working values for display

Behaviour:
- Clock and reset: one clock domain, clk. Reset is synchronous and active-high. All outputs are registered.
- Reset values:
  - state=IDLE; set_time, editing and edit_field are 0.
  - input_*, edit_* and all internal counters are 0.
  - Previous-button registers are 0.
- Press detection: press_x = btn_x & ~btn_x_prev, with btn_x_prev registered every cycle.
- Response latency: an action taken on a press updates registers at the edge that samples the press. The result is visible on the next cycle.
- FSM states: IDLE, EDIT_HOUR, EDIT_MIN, EDIT_SEC, COMMIT.
  - IDLE + press_mode: go to EDIT_HOUR and capture current_24_* into edit_*. Any captured value outside its range (hour>23, min/sec>59) loads as 0.
  - EDIT_HOUR + press_mode: go to EDIT_MIN.
  - EDIT_MIN + press_mode: go to EDIT_SEC.
  - EDIT_SEC + press_mode: go to COMMIT.
  - COMMIT lasts exactly 1 cycle: set_time=1 and input_* = edit_*. It then returns to IDLE unconditionally; buttons are ignored in COMMIT.
  - Any EDIT state + press_cancel: go to IDLE with no set_time.
  - Any EDIT state with idle_cnt reaching TIMEOUT-1: go to IDLE with no set_time.
- Outputs per state:
  - edit_field is 1, 2 or 3 in EDIT_HOUR, EDIT_MIN and EDIT_SEC; 0 otherwise.
  - editing is 1 only in the EDIT states.
  - input_* hold their last committed values outside COMMIT.
- Priority within one cycle: cancel > mode > up/down.
  - If btn_up and btn_down are both high, no step is taken and the hold counter clears.
  - A step is never applied on a cycle where mode or cancel is pressed.
- Step arithmetic, applied to the active field only:
  - hour wraps 23->0 on up and 0->23 on down.
  - min and sec wrap 59->0 on up and 0->59 on down.
- Auto-repeat, while exactly one of up/down is held in an EDIT state:
  - hold_cnt clears on the press edge, which also produces a step (cycle 0).
  - Further steps occur at cycles REPEAT_DELAY, REPEAT_DELAY+REPEAT_RATE, REPEAT_DELAY+2*REPEAT_RATE, ... counted from the press cycle.
  - Releasing the button clears hold_cnt.
  - Changing field with mode while holding up/down stops repeat until a new press edge.
- Timeout counter (idle_cnt, 16 bit):
  - Clears on entry to any EDIT state and on any press edge or repeat step.
  - Otherwise increments in EDIT states and holds at 0 in IDLE and COMMIT.
- Live time while editing: current_24_* changing during a session does not alter edit_*.
- Reset mid-session: the next cycle is IDLE with set_time=0. No commit is produced, even if reset is asserted in COMMIT.

Test Plan:
- Full edit: reset, current=10:20:30. Mode, up x2, mode, down x1, mode, mode → exactly one set_time cycle with input_hour=12, input_min=19, input_sec=30, then editing=0.
- Wrap: in EDIT_HOUR from 23, up → edit_hour=0. In EDIT_SEC from 0, down → edit_sec=59. In EDIT_MIN from 59, up → edit_min=0.
- Auto-repeat: defaults, edit_min=5, hold btn_up for 17 cycles → steps at cycles 0, 8, 12, 16, giving edit_min=9. Release; no further change.
- Cancel and timeout:
  - Cancel from EDIT_MIN → editing=0, set_time never asserted, input_* unchanged.
  - With TIMEOUT=20 and no presses → IDLE after 20 cycles in EDIT, no set_time.
- Conflicts: up+down held together → no change. Mode and up pressed in the same cycle in EDIT_HOUR → EDIT_MIN with edit_hour unchanged.
- Reset mid-operation: assert reset on the COMMIT cycle → set_time=0, state=IDLE, edit_*=0.

Source files
------------

// File: rtl/time_set_controller.sv
// time_set_controller
// Turns debounced front-panel buttons into an hour/minute/second edit session.
// The session ends in a one-cycle commit strobe toward the clock keeper.
//
// Handshake: set_time is a one-cycle valid strobe with no ready. input_hour,
// input_min and input_sec are qualified by set_time and hold their last
// committed values at all other times. The receiver must accept on that cycle.
module time_set_controller #(
  parameter int TIMEOUT      = 1000,
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_cancel,
  input  logic [7:0] current_24_hour,
  input  logic [7:0] current_24_min,
  input  logic [7:0] current_24_sec,
  output logic       set_time,
  output logic [7:0] input_hour,
  output logic [7:0] input_min,
  output logic [7:0] input_sec,
  output logic       editing,
  output logic [1:0] edit_field,
  output logic [7:0] edit_hour,
  output logic [7:0] edit_min,
  output logic [7:0] edit_sec,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_EDIT_HOUR = 3'd1,
    S_EDIT_MIN  = 3'd2,
    S_EDIT_SEC  = 3'd3,
    S_COMMIT    = 3'd4
  } state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
  localparam logic [15:0] DELAY_CNT    = 16'(REPEAT_DELAY);
  localparam logic [15:0] RATE_CNT     = 16'(REPEAT_RATE);

  state_t      state_q, state_d;

  logic        mode_prev_q, up_prev_q, down_prev_q, cancel_prev_q;
  logic        press_mode, press_up, press_down, press_cancel, any_press;

  logic [15:0] idle_cnt_q, idle_cnt_d;
  logic [15:0] hold_cnt_q, hold_cnt_d;
  logic        armed_q, armed_d;
  logic        rate_phase_q, rate_phase_d;

  logic        in_edit, stay_edit, timed_out, one_held;
  logic        press_step, repeat_step, step;

  logic [7:0]  edit_hour_q, edit_hour_d;
  logic [7:0]  edit_min_q, edit_min_d;
  logic [7:0]  edit_sec_q, edit_sec_d;
  logic [7:0]  input_hour_q, input_hour_d;
  logic [7:0]  input_min_q, input_min_d;
  logic [7:0]  input_sec_q, input_sec_d;
  logic        set_time_q, set_time_d;
  logic        editing_q, editing_d;
  logic [1:0]  edit_field_q, edit_field_d;

  function automatic logic is_edit(input state_t s);
    return (s == S_EDIT_HOUR) || (s == S_EDIT_MIN) || (s == S_EDIT_SEC);
  endfunction

  // One wrap-around step of a field whose legal range is 0..max_v.
  function automatic logic [7:0] step_val(input logic [7:0] v,
                                          input logic [7:0] max_v,
                                          input logic       up);
    logic [7:0] r;
    if (up) r = (v >= max_v) ? 8'd0 : v + 8'd1;
    else    r = (v == 8'd0) ? max_v : v - 8'd1;
    return r;
  endfunction

  // Rising-edge detection against the previous-cycle button levels.
  always_comb begin
    press_mode   = btn_mode & ~mode_prev_q;
    press_up     = btn_up & ~up_prev_q;
    press_down   = btn_down & ~down_prev_q;
    press_cancel = btn_cancel & ~cancel_prev_q;
    any_press    = press_mode | press_up | press_down | press_cancel;
    in_edit      = is_edit(state_q);
    timed_out    = in_edit && (idle_cnt_q == TIMEOUT_LAST);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state: cancel beats mode, mode beats timeout; COMMIT is a single cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (press_mode) state_d = S_EDIT_HOUR;
      end
      S_EDIT_HOUR: begin
        if (press_cancel)    state_d = S_IDLE;
        else if (press_mode) state_d = S_EDIT_MIN;
        else if (timed_out)  state_d = S_IDLE;
      end
      S_EDIT_MIN: begin
        if (press_cancel)    state_d = S_IDLE;
        else if (press_mode) state_d = S_EDIT_SEC;
        else if (timed_out)  state_d = S_IDLE;
      end
      S_EDIT_SEC: begin
        if (press_cancel)    state_d = S_IDLE;
        else if (press_mode) state_d = S_COMMIT;
        else if (timed_out)  state_d = S_IDLE;
      end
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Step generation: press edge steps at once; holding arms a delay phase of
  // REPEAT_DELAY cycles followed by a rate phase of REPEAT_RATE cycles per step.
  // hold_cnt holds the number of cycles since the last step in the current phase.
  always_comb begin
    stay_edit    = in_edit && (state_d == state_q);
    one_held     = btn_up ^ btn_down;
    press_step   = stay_edit && one_held && (press_up || press_down);
    repeat_step  = 1'b0;
    armed_d      = 1'b0;
    rate_phase_d = 1'b0;
    hold_cnt_d   = '0;
    if (press_step) begin
      armed_d    = 1'b1;
      hold_cnt_d = 16'd1;
    end else if (stay_edit && one_held && armed_q) begin
      armed_d      = 1'b1;
      rate_phase_d = rate_phase_q;
      if (!rate_phase_q && (hold_cnt_q == DELAY_CNT)) begin
        repeat_step  = 1'b1;
        rate_phase_d = 1'b1;
        hold_cnt_d   = 16'd1;
      end else if (rate_phase_q && (hold_cnt_q == RATE_CNT)) begin
        repeat_step = 1'b1;
        hold_cnt_d  = 16'd1;
      end else begin
        hold_cnt_d = hold_cnt_q + 16'd1;
      end
    end
    step = press_step | repeat_step;
  end

  // Inactivity counter: cleared on entering an edit field and on any activity.
  always_comb begin
    if (!is_edit(state_d) || (state_d != state_q)) idle_cnt_d = '0;
    else if (any_press || step)                    idle_cnt_d = '0;
    else                                           idle_cnt_d = idle_cnt_q + 16'd1;
  end

  // Working values: snapshot live time on session start, then step the active field.
  always_comb begin
    edit_hour_d = edit_hour_q;
    edit_min_d  = edit_min_q;
    edit_sec_d  = edit_sec_q;
    if ((state_q == S_IDLE) && (state_d == S_EDIT_HOUR)) begin
      edit_hour_d = (current_24_hour > 8'd23) ? 8'd0 : current_24_hour;
      edit_min_d  = (current_24_min > 8'd59) ? 8'd0 : current_24_min;
      edit_sec_d  = (current_24_sec > 8'd59) ? 8'd0 : current_24_sec;
    end else if (step) begin
      case (state_q)
        S_EDIT_HOUR: edit_hour_d = step_val(edit_hour_q, 8'd23, btn_up);
        S_EDIT_MIN:  edit_min_d  = step_val(edit_min_q, 8'd59, btn_up);
        S_EDIT_SEC:  edit_sec_d  = step_val(edit_sec_q, 8'd59, btn_up);
        default: ;
      endcase
    end
  end

  // Registered outputs derived from the state being entered.
  always_comb begin
    editing_d    = is_edit(state_d);
    set_time_d   = (state_d == S_COMMIT);
    edit_field_d = 2'd0;
    case (state_d)
      S_EDIT_HOUR: edit_field_d = 2'd1;
      S_EDIT_MIN:  edit_field_d = 2'd2;
      S_EDIT_SEC:  edit_field_d = 2'd3;
      default:     edit_field_d = 2'd0;
    endcase
    input_hour_d = set_time_d ? edit_hour_q : input_hour_q;
    input_min_d  = set_time_d ? edit_min_q : input_min_q;
    input_sec_d  = set_time_d ? edit_sec_q : input_sec_q;
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_prev_q   <= 1'b0;
      up_prev_q     <= 1'b0;
      down_prev_q   <= 1'b0;
      cancel_prev_q <= 1'b0;
      idle_cnt_q    <= '0;
      hold_cnt_q    <= '0;
      armed_q       <= 1'b0;
      rate_phase_q  <= 1'b0;
      edit_hour_q   <= '0;
      edit_min_q    <= '0;
      edit_sec_q    <= '0;
      input_hour_q  <= '0;
      input_min_q   <= '0;
      input_sec_q   <= '0;
      set_time_q    <= 1'b0;
      editing_q     <= 1'b0;
      edit_field_q  <= 2'd0;
    end else begin
      mode_prev_q   <= btn_mode;
      up_prev_q     <= btn_up;
      down_prev_q   <= btn_down;
      cancel_prev_q <= btn_cancel;
      idle_cnt_q    <= idle_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      armed_q       <= armed_d;
      rate_phase_q  <= rate_phase_d;
      edit_hour_q   <= edit_hour_d;
      edit_min_q    <= edit_min_d;
      edit_sec_q    <= edit_sec_d;
      input_hour_q  <= input_hour_d;
      input_min_q   <= input_min_d;
      input_sec_q   <= input_sec_d;
      set_time_q    <= set_time_d;
      editing_q     <= editing_d;
      edit_field_q  <= edit_field_d;
    end
  end

  assign set_time   = set_time_q;
  assign input_hour = input_hour_q;
  assign input_min  = input_min_q;
  assign input_sec  = input_sec_q;
  assign editing    = editing_q;
  assign edit_field = edit_field_q;
  assign edit_hour  = edit_hour_q;
  assign edit_min   = edit_min_q;
  assign edit_sec   = edit_sec_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_time_set_controller.sv
// Bench for time_set_controller: behavioural session model checked every cycle,
// directed scenarios with literal expectations, then randomized button traffic.
module tb_time_set_controller;
  localparam int TO = 20;
  localparam int RD = 8;
  localparam int RR = 4;

  // Clock and reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_cancel = 1'b0;
  logic [7:0] cur_h = 8'd0, cur_m = 8'd0, cur_s = 8'd0;
  logic       set_time, editing;
  logic [7:0] input_hour, input_min, input_sec, edit_hour, edit_min, edit_sec;
  logic [1:0] edit_field;
  logic [2:0] dbg_state;

  time_set_controller #(.TIMEOUT(TO), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
    .clk(clk), .reset(reset),
    .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down), .btn_cancel(btn_cancel),
    .current_24_hour(cur_h), .current_24_min(cur_m), .current_24_sec(cur_s),
    .set_time(set_time), .input_hour(input_hour), .input_min(input_min), .input_sec(input_sec),
    .editing(editing), .edit_field(edit_field),
    .edit_hour(edit_hour), .edit_min(edit_min), .edit_sec(edit_sec),
    .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;
  int set_cnt = 0;
  bit check_en = 1'b0;

  // Behavioural model: field 0 = idle, 1..3 = editing h/m/s, 4 = commit cycle
  int m_field = 0, m_hour = 0, m_min = 0, m_sec = 0;
  int m_in_h = 0, m_in_m = 0, m_in_s = 0, m_set = 0, m_idle = 0, m_age = 0;
  bit m_holding = 1'b0;
  bit p_mode = 1'b0, p_up = 1'b0, p_down = 1'b0, p_cancel = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pack(input logic s, input logic e, input logic [1:0] f,
                                       input logic [7:0] ih, input logic [7:0] im,
                                       input logic [7:0] ins, input logic [7:0] eh,
                                       input logic [7:0] em, input logic [7:0] es);
    return {12'd0, s, e, f, ih, im, ins, eh, em, es};
  endfunction

  task automatic model_step();
    bit pm, pu, pd, pc;
    int old, dir;
    if (reset) begin
      m_field = 0; m_hour = 0; m_min = 0; m_sec = 0;
      m_in_h = 0; m_in_m = 0; m_in_s = 0; m_set = 0;
      m_idle = 0; m_age = 0; m_holding = 1'b0;
      p_mode = 1'b0; p_up = 1'b0; p_down = 1'b0; p_cancel = 1'b0;
    end else begin
      pm = btn_mode & ~p_mode;
      pu = btn_up & ~p_up;
      pd = btn_down & ~p_down;
      pc = btn_cancel & ~p_cancel;
      dir = 0;
      old = m_field;
      m_set = 0;
      if (old == 0) begin
        if (pm) begin
          m_field = 1;
          m_hour = (cur_h > 8'd23) ? 0 : int'(cur_h);
          m_min  = (cur_m > 8'd59) ? 0 : int'(cur_m);
          m_sec  = (cur_s > 8'd59) ? 0 : int'(cur_s);
        end
      end else if (old == 4) m_field = 0;
      else if (pc) m_field = 0;
      else if (pm) m_field = old + 1;
      else if (m_idle == TO - 1) m_field = 0;
      else begin
        if (btn_up && btn_down) m_holding = 1'b0;
        else if (btn_up || btn_down) begin
          if (pu || pd) begin
            m_holding = 1'b1;
            m_age = 0;
            dir = btn_up ? 1 : -1;
          end else if (m_holding) begin
            m_age++;
            if (m_age >= RD && ((m_age - RD) % RR) == 0) dir = btn_up ? 1 : -1;
          end
        end else m_holding = 1'b0;
        if (dir != 0) begin
          if (old == 1)      m_hour = (m_hour + dir + 24) % 24;
          else if (old == 2) m_min  = (m_min + dir + 60) % 60;
          else               m_sec  = (m_sec + dir + 60) % 60;
        end
        if (dir != 0 || pu || pd) m_idle = 0;
        else m_idle++;
      end
      if (m_field != old || m_field == 0 || m_field == 4) begin
        m_idle = 0;
        m_holding = 1'b0;
      end
      if (m_field == 4) begin
        m_set = 1; m_in_h = m_hour; m_in_m = m_min; m_in_s = m_sec;
      end
      p_mode = btn_mode; p_up = btn_up; p_down = btn_down; p_cancel = btn_cancel;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Scoreboard compare every cycle, plus commit strobe counting
  always @(negedge clk) begin
    if (check_en) begin
      chk("cycle_model",
          pack(set_time, editing, edit_field, input_hour, input_min, input_sec,
               edit_hour, edit_min, edit_sec),
          pack(m_set != 0, (m_field >= 1 && m_field <= 3),
               (m_field >= 1 && m_field <= 3) ? 2'(m_field) : 2'd0,
               8'(m_in_h), 8'(m_in_m), 8'(m_in_s), 8'(m_hour), 8'(m_min), 8'(m_sec)));
      if (set_time) set_cnt++;
    end
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(input int which, input logic v);
    case (which)
      0: btn_mode = v;
      1: btn_up = v;
      2: btn_down = v;
      default: btn_cancel = v;
    endcase
  endtask

  task automatic pulse(input int which);
    @(negedge clk);
    set_btn(which, 1'b1);
    @(negedge clk);
    set_btn(which, 1'b0);
  endtask

  task automatic set_cur(input int h, input int m, input int s);
    cur_h = 8'(h); cur_m = 8'(m); cur_s = 8'(s);
  endtask

  int n;

  initial begin
    tick(3);
    check_en = 1'b1;
    reset = 1'b0;
    chk("reset_outputs", pack(set_time, editing, edit_field, input_hour, input_min,
                              input_sec, edit_hour, edit_min, edit_sec), 64'd0);
    chk("reset_state", dbg_state, 0);

    // Full edit session
    set_cur(10, 20, 30);
    pulse(0);
    chk("fe_field_hour", edit_field, 1);
    chk("fe_capture_hour", edit_hour, 10);
    set_cur(3, 4, 5);
    pulse(1);
    pulse(1);
    chk("fe_hour_up2", edit_hour, 12);
    pulse(0);
    pulse(2);
    chk("fe_min_down", edit_min, 19);
    pulse(0);
    pulse(0);
    chk("fe_set_time", set_time, 1);
    chk("fe_inputs", {input_hour, input_min, input_sec}, {8'd12, 8'd19, 8'd30});
    tick(1);
    chk("fe_editing_after", editing, 0);
    chk("fe_one_commit", set_cnt, 1);

    // Wrap-around on each field, then cancel from the seconds field
    set_cur(23, 59, 0);
    pulse(0);
    pulse(1);
    chk("wrap_hour_up", edit_hour, 0);
    pulse(0);
    pulse(1);
    chk("wrap_min_up", edit_min, 0);
    pulse(0);
    pulse(2);
    chk("wrap_sec_down", edit_sec, 59);
    pulse(3);
    tick(1);
    chk("wrap_cancel", {editing, edit_field}, 0);
    chk("wrap_no_commit", set_cnt, 1);

    // Auto-repeat in the minutes field, then cancel
    set_cur(0, 5, 0);
    pulse(0);
    pulse(0);
    @(negedge clk);
    btn_up = 1'b1;
    repeat (17) @(negedge clk);
    btn_up = 1'b0;
    chk("repeat_17", edit_min, 9);
    tick(8);
    chk("repeat_release", edit_min, 9);
    pulse(3);
    tick(1);
    chk("cancel_min_editing", editing, 0);
    chk("cancel_min_inputs", {input_hour, input_min, input_sec}, {8'd12, 8'd19, 8'd30});
    chk("cancel_min_no_commit", set_cnt, 1);

    // Timeout with no activity
    pulse(0);
    n = 1;
    while (editing && n < 100) begin
      @(negedge clk);
      if (editing) n++;
    end
    chk("timeout_cycles", n, TO);
    chk("timeout_no_commit", set_cnt, 1);

    // Up+down together, then mode+up in the same cycle
    set_cur(7, 8, 9);
    pulse(0);
    @(negedge clk);
    btn_up = 1'b1;
    btn_down = 1'b1;
    repeat (12) @(negedge clk);
    chk("both_held", edit_hour, 7);
    btn_up = 1'b0;
    btn_down = 1'b0;
    @(negedge clk);
    btn_mode = 1'b1;
    btn_up = 1'b1;
    @(negedge clk);
    btn_mode = 1'b0;
    btn_up = 1'b0;
    chk("mode_up_field", edit_field, 2);
    chk("mode_up_hour", {edit_hour, edit_min}, {8'd7, 8'd8});
    pulse(3);

    // Out-of-range live values load as zero
    set_cur(200, 60, 59);
    pulse(0);
    chk("range_capture", {edit_hour, edit_min, edit_sec}, {8'd0, 8'd0, 8'd59});
    pulse(3);

    // Reset sampled on the edge that would enter COMMIT
    set_cur(1, 2, 3);
    pulse(0);
    pulse(0);
    pulse(0);
    @(negedge clk);
    btn_mode = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    btn_mode = 1'b0;
    reset = 1'b0;
    chk("rst_commit_outputs", pack(set_time, editing, edit_field, input_hour, input_min,
                                   input_sec, edit_hour, edit_min, edit_sec), 64'd0);
    tick(3);
    chk("rst_commit_no_strobe", set_cnt, 1);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 699) == 0);
      if ($urandom_range(0, 7) == 0)  btn_mode = ~btn_mode;
      if ($urandom_range(0, 11) == 0) btn_up = ~btn_up;
      if ($urandom_range(0, 11) == 0) btn_down = ~btn_down;
      if ($urandom_range(0, 39) == 0) btn_cancel = ~btn_cancel;
      if ($urandom_range(0, 3) == 0) begin
        cur_h = 8'($urandom_range(0, 27));
        cur_m = 8'($urandom_range(0, 63));
        cur_s = 8'($urandom_range(0, 63));
      end
    end
    @(negedge clk);
    reset = 1'b0;
    btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_cancel = 1'b0;
    tick(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
